// File: rtl/jr_pkg.sv
// Shared encodings and helpers for the Johnson/ring counter.
package jr_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // popcount operates on a fixed-width vector; callers zero-extend into it
  localparam int MAX_W = 64;
  localparam int POP_W = 7;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/jr_phase_decode.sv
// Combinational legality check and phase index for a counter value.
// WIDTH must lie in 2..63.
module jr_phase_decode
  import jr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  output logic             legal,
  output logic [PW-1:0]    phase
);

  localparam logic [PW-1:0] TWO_W = PW'(2*WIDTH);

  logic [POP_W-1:0] ones;
  logic [POP_W-1:0] edges;
  logic             j_legal;
  logic             r_legal;
  logic [PW-1:0]    j_phase;
  logic [PW-1:0]    r_phase;

  assign ones  = popcount({{(MAX_W-WIDTH){1'b0}}, count});
  assign edges = popcount({{(MAX_W-WIDTH+1){1'b0}}, count[WIDTH-1:1] ^ count[WIDTH-2:0]});

  assign j_legal = (edges <= POP_W'(1));
  assign r_legal = (ones == POP_W'(1));

  // Filling half counts up in ones; the draining half counts down from 2*WIDTH.
  // Modular arithmetic in PW bits keeps this exact when 2*WIDTH is a power of two.
  always_comb begin
    j_phase = ones[PW-1:0];
    if (!(count[0] || (count == '0))) begin
      j_phase = TWO_W - ones[PW-1:0];
    end
  end

  always_comb begin
    r_phase = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i]) begin
        r_phase = PW'(i);
      end
    end
  end

  always_comb begin
    legal = j_legal;
    phase = j_legal ? j_phase : '0;
    if (mode == MODE_RING) begin
      legal = r_legal;
      phase = r_legal ? r_phase : '0;
    end
  end

endmodule

// File: rtl/johnson_ring_counter.sv
// Johnson / ring shift counter with direction, load, self-correction,
// wrap and error pulses.
module johnson_ring_counter
  import jr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             legal,
  output logic             wrap,
  output logic             err
);

  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             err_next;
  logic             step_legal;
  logic [PW-1:0]    step_phase;

  jr_phase_decode #(.WIDTH(WIDTH)) u_cur_decode (
    .count (count),
    .mode  (mode),
    .legal (legal),
    .phase (phase)
  );

  // Decodes the value a normal step would produce, used only for wrap.
  jr_phase_decode #(.WIDTH(WIDTH)) u_next_decode (
    .count (stepped),
    .mode  (mode),
    .legal (step_legal),
    .phase (step_phase)
  );

  always_comb begin
    stepped = count;
    unique case ({mode, dir})
      {MODE_JOHNSON, DIR_UP}:   stepped = {count[WIDTH-2:0], ~count[WIDTH-1]};
      {MODE_JOHNSON, DIR_DOWN}: stepped = {~count[0], count[WIDTH-1:1]};
      {MODE_RING, DIR_UP}:      stepped = {count[WIDTH-2:0], count[WIDTH-1]};
      {MODE_RING, DIR_DOWN}:    stepped = {count[0], count[WIDTH-1:1]};
      default:                  stepped = count;
    endcase
  end

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    err_next   = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      if (legal) begin
        count_next = stepped;
        wrap_next  = step_legal && (step_phase == '0);
      end else begin
        count_next = (mode == MODE_RING) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
        err_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
      err   <= err_next;
    end
  end

endmodule

// File: tb/tb_johnson_ring_counter.sv
// Bench for johnson_ring_counter at WIDTH 2, 4 and 8: vector table, hand
// sequences for reset corner cases, and model-driven random steps.
module tb_johnson_ring_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic en_v [3];
  logic load_v [3];
  logic mode_v [3];
  logic dir_v [3];
  logic [1:0] lv2;
  logic [3:0] lv4;
  logic [7:0] lv8;

  logic [1:0] count2;
  logic [1:0] phase2;
  logic       legal2, wrap2, err2;
  logic [3:0] count4;
  logic [2:0] phase4;
  logic       legal4, wrap4, err4;
  logic [7:0] count8;
  logic [3:0] phase8;
  logic       legal8, wrap8, err8;

  johnson_ring_counter #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .en(en_v[0]), .mode(mode_v[0]), .dir(dir_v[0]),
    .load(load_v[0]), .load_val(lv2), .count(count2), .phase(phase2),
    .legal(legal2), .wrap(wrap2), .err(err2)
  );

  johnson_ring_counter #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .en(en_v[1]), .mode(mode_v[1]), .dir(dir_v[1]),
    .load(load_v[1]), .load_val(lv4), .count(count4), .phase(phase4),
    .legal(legal4), .wrap(wrap4), .err(err4)
  );

  johnson_ring_counter #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .en(en_v[2]), .mode(mode_v[2]), .dir(dir_v[2]),
    .load(load_v[2]), .load_val(lv8), .count(count8), .phase(phase8),
    .legal(legal8), .wrap(wrap8), .err(err8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [14:0] exp_q[$];
  logic [7:0] m_count [3];
  int wdt [3] = '{2, 4, 8};

  // packed record layout: {count[7:0], phase[3:0], legal, wrap, err}
  function automatic logic [14:0] pack(input logic [7:0] c, input logic [3:0] ph,
                                       input logic lg, input logic wr, input logic er);
    return {c, ph, lg, wr, er};
  endfunction

  function automatic logic [14:0] actual(input int d);
    case (d)
      0:       return pack({6'b0, count2}, {2'b0, phase2}, legal2, wrap2, err2);
      1:       return pack({4'b0, count4}, {1'b0, phase4}, legal4, wrap4, err4);
      default: return pack(count8, phase8, legal8, wrap8, err8);
    endcase
  endfunction

  task automatic chk(input string tag, input string fld, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, fld, got, want);
    end
  endtask

  task automatic compare_next(input string tag, input int d);
    logic [14:0] e;
    logic [14:0] a;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = exp_q.pop_front();
    a = actual(d);
    chk(tag, "count", a[14:7], e[14:7]);
    chk(tag, "phase", {4'b0, a[6:3]}, {4'b0, e[6:3]});
    chk(tag, "legal", {7'b0, a[2]}, {7'b0, e[2]});
    chk(tag, "wrap",  {7'b0, a[1]}, {7'b0, e[1]});
    chk(tag, "err",   {7'b0, a[0]}, {7'b0, e[0]});
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] mask_of(input int w);
    return 8'((1 << w) - 1);
  endfunction

  function automatic logic [7:0] m_shift(input int w, input logic [7:0] s, input logic md, input logic dr);
    logic [7:0] r;
    if (dr == 1'b0) begin
      r = s << 1;
      r[0] = md ? s[w-1] : ~s[w-1];
    end else begin
      r = s >> 1;
      r[w-1] = md ? s[0] : ~s[0];
    end
    return r & mask_of(w);
  endfunction

  // legality and phase by walking the legal sequence from its phase-0 state
  task automatic m_decode(input int w, input logic [7:0] c, input logic md,
                          output logic lg, output logic [3:0] ph);
    logic [7:0] s;
    lg = 1'b0;
    ph = 4'd0;
    s = md ? 8'd1 : 8'd0;
    for (int k = 0; k < (md ? w : 2*w); k++) begin
      if (c == s) begin
        lg = 1'b1;
        ph = 4'(k);
      end
      s = m_shift(w, s, md, 1'b0);
    end
  endtask

  task automatic m_step(input int d, input logic ld, input logic e, input logic md,
                        input logic dr, input logic [7:0] lv, output logic [14:0] exp);
    int w;
    logic [7:0] c, nc;
    logic lg, wr, er, lg2;
    logic [3:0] ph, ph2;
    w = wdt[d];
    c = m_count[d];
    nc = c;
    wr = 1'b0;
    er = 1'b0;
    if (ld) begin
      nc = lv & mask_of(w);
    end else if (e) begin
      m_decode(w, c, md, lg, ph);
      if (lg) begin
        nc = m_shift(w, c, md, dr);
        m_decode(w, nc, md, lg2, ph2);
        wr = (ph2 == 4'd0);
      end else begin
        nc = md ? 8'd1 : 8'd0;
        er = 1'b1;
      end
    end
    m_count[d] = nc;
    m_decode(w, nc, md, lg, ph);
    exp = pack(nc, ph, lg, wr, er);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int d, input logic ld, input logic e, input logic md,
                       input logic dr, input logic [7:0] lv);
    for (int k = 0; k < 3; k++) begin
      en_v[k] = 1'b0;
      load_v[k] = 1'b0;
    end
    en_v[d] = e;
    load_v[d] = ld;
    mode_v[d] = md;
    dir_v[d] = dr;
    case (d)
      0:       lv2 = lv[1:0];
      1:       lv4 = lv[3:0];
      default: lv8 = lv;
    endcase
  endtask

  task automatic step(input int d, input logic ld, input logic e, input logic md,
                      input logic dr, input logic [7:0] lv, input logic [14:0] exp, input string tag);
    @(negedge clk);
    drive(d, ld, e, md, dr, lv);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare_next(tag, d);
  endtask

  // asserts rst between edges, checks DUT d while rst is high, then releases
  task automatic reset_check(input int d, input logic [14:0] exp, input string tag);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      en_v[k] = 1'b0;
      load_v[k] = 1'b0;
      m_count[k] = 8'd0;
    end
    rst = 1'b1;
    #1;
    exp_q.push_back(exp);
    compare_next(tag, d);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       r;
    logic       ld, e, md, dr;
    logic [3:0] lv;
    logic [3:0] c;
    logic [2:0] ph;
    logic       lg, wr, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic ld, input logic e, input logic md,
                              input logic dr, input logic [3:0] lv, input logic [3:0] c,
                              input logic [2:0] ph, input logic lg, input logic wr, input logic er);
    vec_t v;
    v.r = r; v.ld = ld; v.e = e; v.md = md; v.dr = dr; v.lv = lv;
    v.c = c; v.ph = ph; v.lg = lg; v.wr = wr; v.er = er;
    return v;
  endfunction

  initial begin
    logic [14:0] exp;
    logic lg;
    logic [3:0] ph;
    logic md, dr, ld, e;
    logic [7:0] lv;

    for (int k = 0; k < 3; k++) begin
      en_v[k] = 1'b0; load_v[k] = 1'b0; mode_v[k] = 1'b0; dir_v[k] = 1'b0;
      m_count[k] = 8'd0;
    end
    lv2 = '0; lv4 = '0; lv8 = '0;

    // Johnson up through a full period
    tbl.push_back(mk(1,0,0,0,0,4'h0, 4'h0,3'd0,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h1,3'd1,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h3,3'd2,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h7,3'd3,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'hF,3'd4,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'hE,3'd5,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'hC,3'd6,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h8,3'd7,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h0,3'd0,1,1,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h1,3'd1,1,0,0));
    // Johnson down
    tbl.push_back(mk(1,0,0,0,1,4'h0, 4'h0,3'd0,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h8,3'd7,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'hC,3'd6,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'hE,3'd5,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'hF,3'd4,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h7,3'd3,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h3,3'd2,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h1,3'd1,1,0,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h0,3'd0,1,1,0));
    // ring up from reset: first edge corrects
    tbl.push_back(mk(1,0,0,1,0,4'h0, 4'h0,3'd0,0,0,0));
    tbl.push_back(mk(0,0,1,1,0,4'h0, 4'h1,3'd0,1,0,1));
    tbl.push_back(mk(0,0,1,1,0,4'h0, 4'h2,3'd1,1,0,0));
    tbl.push_back(mk(0,0,1,1,0,4'h0, 4'h4,3'd2,1,0,0));
    tbl.push_back(mk(0,0,1,1,0,4'h0, 4'h8,3'd3,1,0,0));
    tbl.push_back(mk(0,0,1,1,0,4'h0, 4'h1,3'd0,1,1,0));
    // illegal Johnson load and recovery
    tbl.push_back(mk(0,1,0,0,0,4'h5, 4'h5,3'd0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h0,3'd0,1,0,1));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h1,3'd1,1,0,0));
    // load beats en, then hold
    tbl.push_back(mk(0,1,1,0,0,4'h7, 4'h7,3'd3,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,4'h0, 4'h7,3'd3,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,4'h0, 4'h7,3'd3,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,4'h0, 4'h7,3'd3,1,0,0));
    // switch to ring mid-count: illegal there, corrected; then ring down
    tbl.push_back(mk(0,0,1,1,0,4'h0, 4'h1,3'd0,1,0,1));
    tbl.push_back(mk(0,0,1,1,1,4'h0, 4'h8,3'd3,1,0,0));
    tbl.push_back(mk(0,0,1,1,1,4'h0, 4'h4,3'd2,1,0,0));
    tbl.push_back(mk(0,0,1,1,1,4'h0, 4'h2,3'd1,1,0,0));
    tbl.push_back(mk(0,0,1,1,1,4'h0, 4'h1,3'd0,1,1,0));
    // back to Johnson: down wraps from phase 1, up wraps from phase 7
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h0,3'd0,1,1,0));
    tbl.push_back(mk(0,0,1,0,1,4'h0, 4'h8,3'd7,1,0,0));
    tbl.push_back(mk(0,0,1,0,0,4'h0, 4'h0,3'd0,1,1,0));

    foreach (tbl[i]) begin
      exp = pack({4'b0, tbl[i].c}, {1'b0, tbl[i].ph}, tbl[i].lg, tbl[i].wr, tbl[i].er);
      if (tbl[i].r) begin
        mode_v[1] = tbl[i].md;
        dir_v[1] = tbl[i].dr;
        reset_check(1, exp, $sformatf("vec%0d_reset", i));
      end else begin
        step(1, tbl[i].ld, tbl[i].e, tbl[i].md, tbl[i].dr, {4'b0, tbl[i].lv}, exp,
             $sformatf("vec%0d", i));
      end
    end

    // reset mid-count clears a pending wrap and overrides load/en on the same edge
    step(1, 1, 0, 0, 0, 8'h0C, pack(8'h0C, 4'd6, 1, 0, 0), "rst_seq_load");
    step(1, 0, 1, 0, 0, 8'h00, pack(8'h08, 4'd7, 1, 0, 0), "rst_seq_step");
    step(1, 0, 1, 0, 0, 8'h00, pack(8'h00, 4'd0, 1, 1, 0), "rst_seq_wrap");
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 8'h0F);
    rst = 1'b1;
    #1;
    exp_q.push_back(pack(8'h00, 4'd0, 1, 0, 0));
    compare_next("rst_async", 1);
    @(posedge clk);
    #1;
    exp_q.push_back(pack(8'h00, 4'd0, 1, 0, 0));
    compare_next("rst_over_load", 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    step(1, 0, 1, 0, 0, 8'h00, pack(8'h01, 4'd1, 1, 0, 0), "rst_release_step");

    // WIDTH=2 and WIDTH=8 boundary periods, then random traffic on all widths
    for (int d = 0; d < 3; d++) begin
      mode_v[d] = 1'b0;
      m_decode(wdt[d], 8'd0, 1'b0, lg, ph);
      reset_check(d, pack(8'd0, ph, lg, 0, 0), $sformatf("w%0d_reset", wdt[d]));
      for (int k = 0; k < 2*wdt[d] + 1; k++) begin
        m_step(d, 0, 1, 0, 0, 8'd0, exp);
        step(d, 0, 1, 0, 0, 8'd0, exp, $sformatf("w%0d_jup%0d", wdt[d], k));
      end
      for (int k = 0; k < 80; k++) begin
        md = ($urandom_range(0, 9) == 0) ? ~mode_v[d] : mode_v[d];
        dr = ($urandom_range(0, 7) == 0) ? ~dir_v[d] : dir_v[d];
        ld = ($urandom_range(0, 9) == 0);
        e  = ($urandom_range(0, 3) != 0);
        lv = 8'($urandom_range(0, 255));
        m_step(d, ld, e, md, dr, lv, exp);
        step(d, ld, e, md, dr, lv, exp, $sformatf("w%0d_rnd%0d", wdt[d], k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
